uart_rx_byte: RTL and testbench

- Byte receiver for the 8N1 UART link. It is the receive-side counterpart of uart_tx_byte and uses the same baud_set encoding.
- Oversamples the asynchronous rx line at 16x baud and votes on the middle samples of each bit.
- Presents each good byte with a one-cycle done pulse. Loopback benches and command parsers consume this output.

---
 rtl/uart_rx_byte.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 16x oversampling with a 3-sample majority vote at mid-bit.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches on parity_err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, tick counters held at 0, waiting for falling edge
// START     | validating the start bit; a high majority is a false start
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit; result decided at subtick 9
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_byte #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] byte_out,
    output logic       uart_rx_done,
    output logic       frame_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [15:0] DIV_2400   = 16'(CLK_FREQ / (2400 * 16));
    localparam logic [15:0] DIV_4800   = 16'(CLK_FREQ / (4800 * 16));
    localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / (9600 * 16));
    localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / (19200 * 16));
    localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / (38400 * 16));
    localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / (57600 * 16));
    localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / (115200 * 16));
    localparam logic [15:0] DIV_230400 = 16'(CLK_FREQ / (230400 * 16));

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [2:0]  r_baud;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_subtick;
    logic [2:0]  r_bit_idx;
    logic [1:0]  r_samp;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte_out;
    logic        r_done;
    logic        r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bit;
    logic        r_parity_err;
`endif

    logic [15:0] w_div;
    logic        w_fall;
    logic        w_run;
    logic        w_tick;
    logic        w_mid_tick;
    logic        w_end_tick;
    logic        w_maj;

    always_comb begin
        w_div = DIV_2400;
        case (r_baud)
            3'd0: w_div = DIV_2400;
            3'd1: w_div = DIV_4800;
            3'd2: w_div = DIV_9600;
            3'd3: w_div = DIV_19200;
            3'd4: w_div = DIV_38400;
            3'd5: w_div = DIV_57600;
            3'd6: w_div = DIV_115200;
            3'd7: w_div = DIV_230400;
            default: w_div = DIV_2400;
        endcase
    end

    assign w_fall     = r_prev & ~r_sync2;
    assign w_run      = (r_state != IDLE) && (r_state != WAIT_HIGH);
    assign w_tick     = w_run && (r_div_cnt == (w_div - 16'd1));
    assign w_mid_tick = w_tick && (r_subtick == 4'd9);
    assign w_end_tick = w_tick && (r_subtick == 4'd15);
    // samples 7 and 8 are registered; sample 9 is the live synced line at the subtick-9 tick
    assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_mid_tick && w_maj) begin
                    w_state_nxt = IDLE;
                end else if (w_end_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_end_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_end_tick) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_mid_tick) begin
                    w_state_nxt = w_maj ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_baud      <= 3'd0;
            r_div_cnt   <= 16'd0;
            r_subtick   <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_samp      <= 2'b00;
            r_shift     <= 8'h00;
            r_byte_out  <= 8'h00;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;

            if (!w_run) begin
                r_div_cnt <= 16'd0;
                r_subtick <= 4'd0;
                r_bit_idx <= 3'd0;
                if ((r_state == IDLE) && w_fall) begin
                    r_baud <= baud_set;
                end
            end else if (w_tick) begin
                r_div_cnt <= 16'd0;
                r_subtick <= r_subtick + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end

            if (w_tick && (r_subtick == 4'd7)) begin
                r_samp[0] <= r_sync2;
            end
            if (w_tick && (r_subtick == 4'd8)) begin
                r_samp[1] <= r_sync2;
            end

            if ((r_state == DATA) && w_mid_tick) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if ((r_state == DATA) && w_end_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if ((r_state == STOP) && w_mid_tick) begin
                if (w_maj) begin
                    r_byte_out <= r_shift;
                    r_done     <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if ((r_state == PARITY) && w_mid_tick) begin
                r_par_bit <= w_maj;
            end
            // a framing error suppresses the parity report
            if ((r_state == STOP) && w_mid_tick && w_maj) begin
                r_parity_err <= r_par_bit ^ (^r_shift);
            end
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign byte_out     = r_byte_out;
    assign uart_rx_done = r_done;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at CLK_FREQ = 50 MHz.
// Stimulus pushes expected output events; a monitor pops and compares on every output pulse.
module tb_uart_rx_byte;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // hand-computed 50e6 / (baud * 16) for baud_set 0..7
    localparam int DIV_B2 = 325;
    localparam int DIV_B6 = 27;
    localparam int DIV_B7 = 13;

    typedef struct {
        logic       done;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
        int         tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [2:0] baud_set;
    logic [7:0] byte_out;
    logic       uart_rx_done;
    logic       frame_err;
    logic       parity_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    uart_rx_byte #(.CLK_FREQ(50000000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .baud_set     (baud_set),
        .byte_out     (byte_out),
        .uart_rx_done (uart_rx_done),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic done, input logic ferr, input logic perr,
                            input logic [7:0] data, input int tag);
        exp_t e;
        e.done = done;
        e.ferr = ferr;
        e.perr = perr;
        e.data = data;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // stop_hold_bits = 0 sends a good stop bit; otherwise the line stays low that many bit times
    task automatic send_frame(input logic [7:0] d, input int div, input int stop_hold_bits,
                              input logic par_flip);
        int   bc;
        logic pb;
        bc = div * 16;
        pb = (^d) ^ par_flip;
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) drive(d[i], bc);
        if (PAR_EN) drive(pb, bc);
        if (stop_hold_bits == 0) drive(1'b1, bc);
        else drive(1'b0, bc * stop_hold_bits);
        uart_rx = 1'b1;
    endtask

    // monitor: one comparison per output pulse, plus a one-cycle width check on done
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_rx_done || frame_err || parity_err) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got done=%0b ferr=%0b perr=%0b byte=%02h expected no output",
                             uart_rx_done, frame_err, parity_err, byte_out);
                end else begin
                    e = sb.pop_front();
                    if (uart_rx_done !== e.done || frame_err !== e.ferr ||
                        parity_err !== e.perr || byte_out !== e.data) begin
                        n_errors++;
                        $display("FAIL event%0d: got done=%0b ferr=%0b perr=%0b byte=%02h expected done=%0b ferr=%0b perr=%0b byte=%02h",
                                 e.tag, uart_rx_done, frame_err, parity_err, byte_out,
                                 e.done, e.ferr, e.perr, e.data);
                    end
                end
            end
            if (uart_rx_done) begin
                n_checks++;
                if (prev_done) begin
                    n_errors++;
                    $display("FAIL done_width: got done high 2+ cycles expected 1 cycle");
                end
            end
            prev_done = uart_rx_done;
        end
    end

    initial begin
        int w;
        uart_rx  = 1'b1;
        baud_set = 3'd6;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_byte_out", byte_out, 8'h00);
        chk("reset_done", {7'd0, uart_rx_done}, 8'h00);
        chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
        chk("reset_parity_err", {7'd0, parity_err}, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0x55 at 115200
        push_exp(1'b1, 1'b0, 1'b0, 8'h55, 1);
        send_frame(8'h55, DIV_B6, 0, 1'b0);
        drive(1'b1, DIV_B6 * 32);

        // 20-clk low glitch: false start, nothing reported
        baud_set = 3'd7;
        drive(1'b0, 20);
        drive(1'b1, DIV_B7 * 32);
        chk("glitch_byte_out", byte_out, 8'h55);

        // back-to-back frames with no idle gap
        push_exp(1'b1, 1'b0, 1'b0, 8'h00, 2);
        push_exp(1'b1, 1'b0, 1'b0, 8'hFF, 3);
        send_frame(8'h00, DIV_B7, 0, 1'b0);
        send_frame(8'hFF, DIV_B7, 0, 1'b0);
        drive(1'b1, DIV_B7 * 16);

        // framing error with line held low, then a good frame after recovery
        push_exp(1'b0, 1'b1, 1'b0, 8'hFF, 4);
        send_frame(8'hA5, DIV_B7, 3, 1'b0);
        chk("ferr_byte_held", byte_out, 8'hFF);
        drive(1'b1, DIV_B7 * 32);
        push_exp(1'b1, 1'b0, 1'b0, 8'h3C, 5);
        send_frame(8'h3C, DIV_B7, 0, 1'b0);
        drive(1'b1, DIV_B7 * 16);

        // 9600 frame, baud_set changed mid-frame
        baud_set = 3'd2;
        push_exp(1'b1, 1'b0, 1'b0, 8'hC3, 6);
        fork
            send_frame(8'hC3, DIV_B2, 0, 1'b0);
            begin
                repeat (DIV_B2 * 16 * 3) @(negedge clk);
                baud_set = 3'd6;
            end
        join
        drive(1'b1, DIV_B7 * 16);

        // reset during data bit 4; the transmitter abandons the frame at the same moment
        baud_set = 3'd7;
        drive(1'b0, DIV_B7 * 16);
        for (int i = 0; i < 4; i++) drive(w_bit(8'h81, i), DIV_B7 * 16);
        drive(1'b0, DIV_B7 * 8);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_byte_out", byte_out, 8'h00);
        drive(1'b1, DIV_B7 * 32);
        push_exp(1'b1, 1'b0, PAR_EN, 8'h81, 7);
        send_frame(8'h81, DIV_B7, 0, 1'b1);
        drive(1'b1, DIV_B7 * 16);
        chk("final_byte_out", byte_out, 8'h81);

        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic logic w_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule
